// File: rtl/regfile_dump_reader.sv
// Halts the core and streams register-file entries 0..NREGS-1 over a valid/ready port.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump_reader #(
  parameter int unsigned DBITS = 32,
  parameter int unsigned NREGS = 16,
  parameter int unsigned IBITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             halt_req,
  input  logic             halt_ack,
  output logic [IBITS-1:0] rd_idx,
  input  logic [DBITS-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic [IBITS-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [IBITS-1:0] LastIdx = IBITS'(NREGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHalt, StLoad, StSend, StCsum, StDone} state_e;
  logic [DBITS-1:0] csum_q;
`else
  typedef enum logic [2:0] {StIdle, StHalt, StLoad, StSend, StDone} state_e;
`endif

  state_e           state_q;
  logic [IBITS-1:0] idx_q;

  assign rd_idx = idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      halt_req  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StHalt;
            idx_q    <= '0;
            halt_req <= 1'b1;
            busy     <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q   <= '0;
`endif
          end
        end
        StHalt: begin
          if (halt_ack) state_q <= StLoad;
        end
        StLoad: begin
          out_data  <= rd_data;
          out_idx   <= idx_q;
          out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          csum_q    <= csum_q ^ rd_data;
`else
          out_last  <= (idx_q == LastIdx);
`endif
          state_q   <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx_q == LastIdx) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              state_q <= StCsum;
`else
              state_q <= StDone;
              done    <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StLoad;
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        // First cycle presents the checksum beat; it then waits for acceptance.
        StCsum: begin
          if (!out_valid) begin
            out_data  <= csum_q;
            out_idx   <= LastIdx;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end
`endif
        StDone: begin
          done     <= 1'b0;
          halt_req <= 1'b0;
          busy     <= 1'b0;
          idx_q    <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a scoreboard of expected output beats.
module tb_regfile_dump_reader;
  localparam int DBITS = 32;
  localparam int NREGS = 16;
  localparam int IBITS = 4;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int NBEATS = NREGS + 1;
`else
  localparam int NBEATS = NREGS;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             halt_req;
  logic             halt_ack;
  logic [IBITS-1:0] rd_idx;
  logic [DBITS-1:0] rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [DBITS-1:0] out_data;
  logic [IBITS-1:0] out_idx;
  logic             out_last;
  logic             busy;
  logic             done;

  logic [DBITS-1:0] rf [NREGS];

  typedef struct packed {
    logic [IBITS-1:0] idx;
    logic [DBITS-1:0] data;
    logic             last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  int    beat_cnt = 0;
  beat_t held;
  bit    stalled = 0;

  always #5 clk = ~clk;

  assign rd_data = rf[rd_idx];

  regfile_dump_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .halt_req  (halt_req),
    .halt_ack  (halt_ack),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [DBITS-1:0] obs, input logic [DBITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats for one complete dump of the current register contents.
  task automatic push_dump();
    logic [DBITS-1:0] x;
    x = '0;
    for (int i = 0; i < NREGS; i++) begin
      x ^= rf[i];
`ifdef REGFILE_DUMP_CHECKSUM_EN
      sb.push_back({IBITS'(i), rf[i], 1'b0});
`else
      sb.push_back({IBITS'(i), rf[i], (i == NREGS - 1)});
`endif
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    sb.push_back({IBITS'(NREGS - 1), x, 1'b1});
`endif
  endtask

  // Beats are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 0;
    end else begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (stalled) begin
          chk("stall_data", out_data, held.data);
          chk("stall_idx", DBITS'(out_idx), DBITS'(held.idx));
          chk("stall_last", DBITS'(out_last), DBITS'(held.last));
        end
        held = {out_idx, out_data, out_last};
        if (out_ready) begin
          beat_t e;
          beat_cnt++;
          chk("beat_expected", DBITS'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("beat_idx", DBITS'(out_idx), DBITS'(e.idx));
            chk("beat_data", out_data, e.data);
            chk("beat_last", DBITS'(out_last), DBITS'(e.last));
          end
        end
        stalled = !out_ready;
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic start_dump();
    done_cnt = 0;
    beat_cnt = 0;
    @(posedge clk); #1;
    chk("idle_halt_req", DBITS'(halt_req), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("halt_req_rise", DBITS'(halt_req), 1);
    chk("busy_rise", DBITS'(busy), 1);
  endtask

  // mode 0: ready high; 1: random ready with 5-cycle stall on beat 3;
  // 2: extra start pulse at beat 9; 3: reset while beat 7 is held.
  task automatic run_dump(input int mode);
    int cyc = 0;
    int stall_left = 0;
    bit stall_done = 0;
    bit start_done = 0;
    bit aborted = 0;
    while (done_cnt == 0 && !aborted && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = 1'b1;
      start = 1'b0;
      case (mode)
        1: begin
          if (stall_left > 0 || (out_valid && out_idx == 3 && !stall_done)) begin
            if (!stall_done) stall_left = 5;
            stall_done = 1;
            stall_left--;
            out_ready = 1'b0;
            chk("stall3_valid", DBITS'(out_valid), 1);
            chk("stall3_data", out_data, rf[3]);
            chk("stall3_idx", DBITS'(out_idx), 3);
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
        end
        2: if (out_valid && out_idx == 9 && !start_done) begin
          start = 1'b1;
          start_done = 1;
        end
        3: if (out_valid && out_idx == 7) begin
          out_ready = 1'b0;
          reset_n = 1'b0;
          #1;
          chk("rst_out_valid", DBITS'(out_valid), 0);
          chk("rst_out_last", DBITS'(out_last), 0);
          chk("rst_halt_req", DBITS'(halt_req), 0);
          chk("rst_busy", DBITS'(busy), 0);
          chk("rst_done", DBITS'(done), 0);
          chk("rst_out_data", out_data, 0);
          chk("rst_out_idx", DBITS'(out_idx), 0);
          chk("rst_rd_idx", DBITS'(rd_idx), 0);
          aborted = 1;
        end
        default: ;
      endcase
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (mode == 3) begin
      chk("rst_reached", DBITS'(aborted), 1);
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("rst_no_done", DBITS'(done_cnt), 0);
    end else begin
      chk("done_seen", DBITS'(done_cnt), 1);
      chk("beat_count", DBITS'(beat_cnt), DBITS'(NBEATS));
      chk("sb_empty", DBITS'(sb.size()), 0);
      chk("busy_after", DBITS'(busy), 0);
      chk("halt_req_after", DBITS'(halt_req), 0);
      chk("done_after", DBITS'(done), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_single", DBITS'(done_cnt), 1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    halt_ack = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) rf[i] = DBITS'(32'h100 + i);
    #12;
    chk("reset_valid", DBITS'(out_valid), 0);
    chk("reset_busy", DBITS'(busy), 0);
    chk("reset_done", DBITS'(done), 0);
    chk("reset_data", out_data, 0);
    chk("reset_rd_idx", DBITS'(rd_idx), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic dump, ready tied high.
    push_dump();
    start_dump();
    run_dump(0);

    // Halt handshake delayed by 10 cycles.
    halt_ack = 1'b0;
    push_dump();
    start_dump();
    repeat (10) begin
      @(posedge clk); #1;
      chk("wait_halt_req", DBITS'(halt_req), 1);
      chk("wait_valid", DBITS'(out_valid), 0);
      chk("wait_rd_idx", DBITS'(rd_idx), 0);
    end
    halt_ack = 1'b1;
    @(posedge clk); #1;
    chk("ack_plus1_valid", DBITS'(out_valid), 0);
    @(posedge clk); #1;
    chk("ack_plus2_valid", DBITS'(out_valid), 1);
    run_dump(0);

    // Random backpressure with a long stall on beat 3.
    push_dump();
    start_dump();
    run_dump(1);

    // Reset mid-dump, then a fresh dump from index 0.
    push_dump();
    start_dump();
    run_dump(3);
    push_dump();
    start_dump();
    run_dump(0);

    // Start during a dump is ignored.
    push_dump();
    start_dump();
    run_dump(2);

    // r[i] = i: XOR of all values is zero.
    for (int i = 0; i < NREGS; i++) rf[i] = DBITS'(i);
    push_dump();
    start_dump();
    run_dump(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
